pcie_rx_tlp_demux: RTL and testbench
====================================

// Module: pcie_rx_tlp_demux
// PURPOSE
// - Directly downstream of the PCIe RX AVST->AXIS bridge; consumes its multi-channel AXIS RX stream.
// - Splits TLPs onto two AXIS outputs: MMIO requests (tuser.mmio_req=1 at SOP) and everything else (completions/DMA).
// - Keeps whole-TLP routing across beats. Registers both outputs, one cycle of latency.
// PARAMETERS
// - NUM_CH     2   TLP channels per beat (= FIM_PCIE_TLP_CH).
// - ERR_CNT_W  16  Width of the protocol-error counter (used only when the optional feature is compiled in).
// PORTS
// - avl_clk        in   1    Sole clock; all ports synchronous to it.
// - avl_rst        in   1    Asynchronous, active-high reset.
// - rx_in          in   t_axis_pcie_rxs  Input beat: tvalid, tdata[NUM_CH], tuser[NUM_CH], tlast.
// - rx_in_tready   out  1    Input accept.
// - mmio_out       out  t_axis_pcie_rxs  MMIO-request stream.
// - mmio_tready    in   1    MMIO sink ready.
// - dma_out        out  t_axis_pcie_rxs  Non-MMIO stream.
// - dma_tready     in   1    DMA sink ready.
// - err_cnt        out  ERR_CNT_W  Saturating protocol-error count (PCIE_RX_DEMUX_ERR_EN only).
// BEHAVIOUR
// - Reset values:
//   - mmio_out.tvalid=0, dma_out.tvalid=0; all tdata[ch].valid=0.
//   - route state=IDLE, err_cnt=0, rx_in_tready=0 while avl_rst is high.
// - Route state machine (tracks the one TLP that may be open across beats):
//   - IDLE / OPEN_MMIO / OPEN_DMA.
//   - Channels are processed in order ch0..ch(NUM_CH-1) inside a beat.
//   - A valid SOP channel selects its destination from its own tuser.mmio_req.
//   - A valid non-SOP channel inherits the destination of the open TLP.
//   - A channel with SOP and no EOP sets the state to OPEN_MMIO or OPEN_DMA.
//   - A channel with EOP sets the state to IDLE; SOP and EOP on the same channel leaves the state IDLE.
//   - The state updates only when the beat is accepted.
// - Beat split:
//   - Compute need_mmio and need_dma (any channel routed to that output).
//   - Each output copy carries the input beat with tdata[ch].valid, sop and eop cleared on channels routed elsewhere.
//   - hdr, payload and tuser are copied unchanged. tlast=1.
// - Handshake:
//   - out_ld_X = ~X_out.tvalid | X_tready.
//   - rx_in_tready = (~need_mmio | out_ld_mmio) & (~need_dma | out_ld_dma), combinational.
//   - On accept (rx_in.tvalid & rx_in_tready), each needed output register loads with tvalid=1.
//   - An output not needed that has out_ld=1 clears its tvalid.
//   - A beat is never partially accepted: both halves go out in the same cycle, or neither does.
//   - An input with tvalid=1 and no valid channel is accepted and dropped.
// - Output stability: X_out holds while X_out.tvalid & ~X_tready (standard AXIS).
// - Throughput: one beat per cycle when the needed sinks are ready. Latency is exactly one cycle, input accept to output tvalid.
// - Protocol violations:
//   - Cases: a non-SOP valid channel while IDLE (drop that channel); an SOP while OPEN_* (the open TLP is abandoned and the new SOP routes by its own mmio_req).
//   - Both cases are a single error event per offending channel.
// - Reset asserted mid-TLP: outputs drop immediately; state returns to IDLE; the first post-reset beat must start with an SOP.
// CONFIGURATION
// - PCIE_RX_DEMUX_ERR_EN defined:
//   - err_cnt increments by the number of error events on each accepted beat.
//   - err_cnt saturates at all-ones.
// - PCIE_RX_DEMUX_ERR_EN undefined:
//   - err_cnt is tied to 0 and the counter logic is absent.
//   - Violations are still dropped or abandoned exactly as above.
// TESTING
// - MMIO single-beat TLP on ch0 (sop=eop=1, mmio_req=1), both sinks ready:
//   - mmio_out.tvalid=1 next cycle with ch0 valid; dma_out.tvalid stays 0.
// - Beat with ch0 = completion (sop/eop) and ch1 = MMIO (sop/eop):
//   - Both outputs valid in the same cycle, each carrying only its own channel.
// - DMA TLP: SOP on ch1 of beat 0, continuation on ch0/ch1 of beat 1, EOP on ch0 of beat 2:
//   - All three beats appear on dma_out; state is IDLE after beat 2.
// - Mixed beat with dma_tready=0 and dma_out already valid:
//   - rx_in_tready=0, mmio_out is not loaded; both load on the cycle dma_tready=1.
// - With PCIE_RX_DEMUX_ERR_EN: continuation channel while IDLE, then an SOP while OPEN_MMIO:
//   - err_cnt=2; the orphan channel is dropped; the new SOP routes by its own mmio_req.
// - avl_rst pulsed while OPEN_DMA:
//   - Outputs tvalid=0 asynchronously; after release, the next SOP routes correctly and err_cnt=0.

Source files
------------

// File: rtl/pcie_rx_tlp_demux.sv
// Splits the multi-channel PCIe RX AXIS stream into MMIO-request and DMA/completion streams; one registered cycle,
// beat stalls until every needed output can load. Optional saturating protocol-error counter: PCIE_RX_DEMUX_ERR_EN.

package pcie_rx_tlp_demux_pkg;
  localparam int FIM_PCIE_TLP_CH = 2;
  localparam int HDR_W           = 32;
  localparam int PAYLOAD_W       = 32;

  typedef struct packed {
    logic                 valid;
    logic                 sop;
    logic                 eop;
    logic [HDR_W-1:0]     hdr;
    logic [PAYLOAD_W-1:0] payload;
  } t_tlp_ch;

  typedef struct packed {
    logic       mmio_req;
    logic [6:0] misc;
  } t_tlp_user;

  typedef struct packed {
    logic                                 tvalid;
    logic                                 tlast;
    t_tlp_user [FIM_PCIE_TLP_CH-1:0]      tuser;
    t_tlp_ch   [FIM_PCIE_TLP_CH-1:0]      tdata;
  } t_axis_pcie_rxs;
endpackage

module pcie_rx_tlp_demux
  import pcie_rx_tlp_demux_pkg::*;
#(
  parameter int NUM_CH    = FIM_PCIE_TLP_CH,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 avl_clk,
  input  logic                 avl_rst,
  input  t_axis_pcie_rxs       rx_in,
  output logic                 rx_in_tready,
  output t_axis_pcie_rxs       mmio_out,
  input  logic                 mmio_tready,
  output t_axis_pcie_rxs       dma_out,
  input  logic                 dma_tready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_OPEN_MMIO = 2'd1;
  localparam logic [1:0] ST_OPEN_DMA  = 2'd2;

  logic [1:0]        route_q;
  logic [1:0]        route_nxt;
  logic [NUM_CH-1:0] to_mmio;
  logic [NUM_CH-1:0] to_dma;
  logic              need_mmio;
  logic              need_dma;
  logic              out_ld_mmio;
  logic              out_ld_dma;
  logic              accept;
  t_axis_pcie_rxs    mmio_q;
  t_axis_pcie_rxs    dma_q;
  t_axis_pcie_rxs    mmio_nxt;
  t_axis_pcie_rxs    dma_nxt;

`ifdef PCIE_RX_DEMUX_ERR_EN
  localparam int EV_W = $clog2(NUM_CH + 1);
  logic [EV_W-1:0] err_events;
`endif

  // Walk channels in order so a TLP closing on chN and one opening on chN+1 resolve within the same beat.
  always_comb begin
    route_nxt = route_q;
    to_mmio   = '0;
    to_dma    = '0;
`ifdef PCIE_RX_DEMUX_ERR_EN
    err_events = '0;
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rx_in.tdata[ch].valid) begin
        if (rx_in.tdata[ch].sop) begin
`ifdef PCIE_RX_DEMUX_ERR_EN
          if (route_nxt != ST_IDLE) err_events = err_events + EV_W'(1);
`endif
          to_mmio[ch] = rx_in.tuser[ch].mmio_req;
          to_dma[ch]  = ~rx_in.tuser[ch].mmio_req;
          if (rx_in.tdata[ch].eop) route_nxt = ST_IDLE;
          else route_nxt = rx_in.tuser[ch].mmio_req ? ST_OPEN_MMIO : ST_OPEN_DMA;
        end else if (route_nxt == ST_IDLE) begin
`ifdef PCIE_RX_DEMUX_ERR_EN
          err_events = err_events + EV_W'(1);
`endif
        end else begin
          to_mmio[ch] = (route_nxt == ST_OPEN_MMIO);
          to_dma[ch]  = (route_nxt == ST_OPEN_DMA);
          if (rx_in.tdata[ch].eop) route_nxt = ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    mmio_nxt        = rx_in;
    dma_nxt         = rx_in;
    mmio_nxt.tvalid = 1'b1;
    dma_nxt.tvalid  = 1'b1;
    mmio_nxt.tlast  = 1'b1;
    dma_nxt.tlast   = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!to_mmio[ch]) begin
        mmio_nxt.tdata[ch].valid = 1'b0;
        mmio_nxt.tdata[ch].sop   = 1'b0;
        mmio_nxt.tdata[ch].eop   = 1'b0;
      end
      if (!to_dma[ch]) begin
        dma_nxt.tdata[ch].valid = 1'b0;
        dma_nxt.tdata[ch].sop   = 1'b0;
        dma_nxt.tdata[ch].eop   = 1'b0;
      end
    end
  end

  assign need_mmio    = |to_mmio;
  assign need_dma     = |to_dma;
  assign out_ld_mmio  = ~mmio_q.tvalid | mmio_tready;
  assign out_ld_dma   = ~dma_q.tvalid | dma_tready;
  assign rx_in_tready = ~avl_rst & (~need_mmio | out_ld_mmio) & (~need_dma | out_ld_dma);
  assign accept       = rx_in.tvalid & rx_in_tready;

  always_ff @(posedge avl_clk or posedge avl_rst) begin
    if (avl_rst) begin
      route_q <= ST_IDLE;
      mmio_q  <= '0;
      dma_q   <= '0;
    end else begin
      if (accept) route_q <= route_nxt;
      if (accept && need_mmio) mmio_q <= mmio_nxt;
      else if (out_ld_mmio) mmio_q.tvalid <= 1'b0;
      if (accept && need_dma) dma_q <= dma_nxt;
      else if (out_ld_dma) dma_q.tvalid <= 1'b0;
    end
  end

  assign mmio_out = mmio_q;
  assign dma_out  = dma_q;

`ifdef PCIE_RX_DEMUX_ERR_EN
  logic [ERR_CNT_W:0]   err_sum;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(err_events);

  always_ff @(posedge avl_clk or posedge avl_rst) begin
    if (avl_rst) err_cnt_q <= '0;
    else if (accept) err_cnt_q <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pcie_rx_tlp_demux.sv
// Directed bench for pcie_rx_tlp_demux: routing, multi-beat TLPs, backpressure, protocol errors, mid-TLP reset.
module tb_pcie_rx_tlp_demux;
  import pcie_rx_tlp_demux_pkg::*;

  logic           avl_clk;
  logic           avl_rst;
  t_axis_pcie_rxs rx_in;
  logic           rx_in_tready;
  t_axis_pcie_rxs mmio_out;
  logic           mmio_tready;
  t_axis_pcie_rxs dma_out;
  logic           dma_tready;
  logic [15:0]    err_cnt;

  int n_checks;
  int n_errors;
  logic [15:0] err_exp;

  pcie_rx_tlp_demux #(.NUM_CH(2), .ERR_CNT_W(16)) dut (
    .avl_clk      (avl_clk),
    .avl_rst      (avl_rst),
    .rx_in        (rx_in),
    .rx_in_tready (rx_in_tready),
    .mmio_out     (mmio_out),
    .mmio_tready  (mmio_tready),
    .dma_out      (dma_out),
    .dma_tready   (dma_tready),
    .err_cnt      (err_cnt)
  );

  initial avl_clk = 1'b0;
  always #5 avl_clk = ~avl_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge avl_clk);
    #1;
  endtask

  task automatic clear_beat();
    rx_in = '0;
  endtask

  task automatic set_ch(input int ch, input bit v, input bit s, input bit e, input bit m,
                        input logic [31:0] hdr);
    rx_in.tdata[ch].valid   = v;
    rx_in.tdata[ch].sop     = s;
    rx_in.tdata[ch].eop     = e;
    rx_in.tdata[ch].hdr     = hdr;
    rx_in.tdata[ch].payload = ~hdr;
    rx_in.tuser[ch].mmio_req = m;
    rx_in.tuser[ch].misc     = 7'h15;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    mmio_tready = 1'b1;
    dma_tready  = 1'b1;
    avl_rst     = 1'b1;
    clear_beat();
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 1, 1, 32'h0000_00A0);

    // Reset state, with a valid beat pending at the input
    step();
    step();
    check("rst_mmio_vld", mmio_out.tvalid, 0);
    check("rst_dma_vld", dma_out.tvalid, 0);
    check("rst_ch0_vld", mmio_out.tdata[0].valid, 0);
    check("rst_tready", rx_in_tready, 0);
    check("rst_err", err_cnt, 0);
    check("rst_state", dut.route_q, 0);
    avl_rst = 1'b0;
    clear_beat();
    step();

    // Single-beat MMIO on ch0
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 1, 1, 32'h0000_00A1);
    #1;
    check("mmio1_tready", rx_in_tready, 1);
    step();
    clear_beat();
    check("mmio1_vld", mmio_out.tvalid, 1);
    check("mmio1_ch0_vld", mmio_out.tdata[0].valid, 1);
    check("mmio1_ch0_hdr", mmio_out.tdata[0].hdr, 32'h0000_00A1);
    check("mmio1_ch0_pl", mmio_out.tdata[0].payload, 32'hFFFF_FF5E);
    check("mmio1_tlast", mmio_out.tlast, 1);
    check("mmio1_dma_vld", dma_out.tvalid, 0);
    step();
    check("mmio1_drain", mmio_out.tvalid, 0);

    // Mixed beat: ch0 completion, ch1 MMIO
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 1, 0, 32'h0000_00B0);
    set_ch(1, 1, 1, 1, 1, 32'h0000_00B1);
    step();
    clear_beat();
    check("mix_mmio_vld", mmio_out.tvalid, 1);
    check("mix_mmio_ch0", mmio_out.tdata[0].valid, 0);
    check("mix_mmio_ch0_sop", mmio_out.tdata[0].sop, 0);
    check("mix_mmio_ch1", mmio_out.tdata[1].valid, 1);
    check("mix_mmio_ch1_hdr", mmio_out.tdata[1].hdr, 32'h0000_00B1);
    check("mix_dma_vld", dma_out.tvalid, 1);
    check("mix_dma_ch0", dma_out.tdata[0].valid, 1);
    check("mix_dma_ch0_hdr", dma_out.tdata[0].hdr, 32'h0000_00B0);
    check("mix_dma_ch1", dma_out.tdata[1].valid, 0);
    check("mix_dma_ch1_eop", dma_out.tdata[1].eop, 0);
    step();

    // Three-beat DMA TLP; continuation carries mmio_req=1 which must be ignored
    rx_in.tvalid = 1'b1;
    set_ch(1, 1, 1, 0, 0, 32'h0000_00D1);
    step();
    check("dma3_b0_vld", dma_out.tvalid, 1);
    check("dma3_b0_ch0", dma_out.tdata[0].valid, 0);
    check("dma3_b0_ch1", dma_out.tdata[1].valid, 1);
    check("dma3_b0_state", dut.route_q, 2);
    clear_beat();
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 0, 0, 1, 32'h0000_00D2);
    set_ch(1, 1, 0, 0, 0, 32'h0000_00D3);
    step();
    check("dma3_b1_ch0_hdr", dma_out.tdata[0].hdr, 32'h0000_00D2);
    check("dma3_b1_ch0", dma_out.tdata[0].valid, 1);
    check("dma3_b1_ch1", dma_out.tdata[1].valid, 1);
    check("dma3_b1_mmio", mmio_out.tvalid, 0);
    clear_beat();
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 0, 1, 0, 32'h0000_00D4);
    step();
    clear_beat();
    check("dma3_b2_vld", dma_out.tvalid, 1);
    check("dma3_b2_eop", dma_out.tdata[0].eop, 1);
    check("dma3_b2_ch1", dma_out.tdata[1].valid, 0);
    check("dma3_b2_mmio", mmio_out.tvalid, 0);
    check("dma3_state", dut.route_q, 0);
    step();

    // Empty valid beat is accepted and dropped
    rx_in.tvalid = 1'b1;
    #1;
    check("empty_tready", rx_in_tready, 1);
    step();
    clear_beat();
    check("empty_mmio", mmio_out.tvalid, 0);
    check("empty_dma", dma_out.tvalid, 0);

    // Backpressure: dma held full, mixed beat must wait as a whole
    dma_tready = 1'b0;
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 1, 0, 32'h0000_00E0);
    step();
    check("bp_dma_vld", dma_out.tvalid, 1);
    clear_beat();
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 1, 0, 32'h0000_00E1);
    set_ch(1, 1, 1, 1, 1, 32'h0000_00E2);
    #1;
    check("bp_tready_lo", rx_in_tready, 0);
    step();
    check("bp_mmio_hold", mmio_out.tvalid, 0);
    check("bp_dma_hdr_hold", dma_out.tdata[0].hdr, 32'h0000_00E0);
    dma_tready = 1'b1;
    #1;
    check("bp_tready_hi", rx_in_tready, 1);
    step();
    clear_beat();
    check("bp_mmio_vld", mmio_out.tvalid, 1);
    check("bp_mmio_hdr", mmio_out.tdata[1].hdr, 32'h0000_00E2);
    check("bp_dma_vld2", dma_out.tvalid, 1);
    check("bp_dma_hdr", dma_out.tdata[0].hdr, 32'h0000_00E1);
    step();

    // Orphan continuation while IDLE, then SOP while OPEN_MMIO
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 0, 0, 0, 32'h0000_00C0);
    set_ch(1, 1, 1, 0, 1, 32'h0000_00C1);
    step();
    check("err_b0_mmio_vld", mmio_out.tvalid, 1);
    check("err_b0_orphan", mmio_out.tdata[0].valid, 0);
    check("err_b0_ch1", mmio_out.tdata[1].valid, 1);
    check("err_b0_dma", dma_out.tvalid, 0);
    check("err_b0_state", dut.route_q, 1);
    clear_beat();
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 1, 0, 32'h0000_00C2);
    step();
    clear_beat();
    check("err_b1_dma_vld", dma_out.tvalid, 1);
    check("err_b1_dma_hdr", dma_out.tdata[0].hdr, 32'h0000_00C2);
    check("err_b1_mmio", mmio_out.tvalid, 0);
    check("err_b1_state", dut.route_q, 0);
`ifdef PCIE_RX_DEMUX_ERR_EN
    err_exp = 16'd2;
`else
    err_exp = 16'd0;
`endif
    check("err_cnt", err_cnt, err_exp);
    step();

    // Reset pulsed while OPEN_DMA
    rx_in.tvalid = 1'b1;
    set_ch(0, 1, 1, 0, 0, 32'h0000_00F0);
    step();
    clear_beat();
    check("rst2_pre_dma", dma_out.tvalid, 1);
    avl_rst = 1'b1;
    #1;
    check("rst2_dma_async", dma_out.tvalid, 0);
    check("rst2_tready", rx_in_tready, 0);
    step();
    avl_rst = 1'b0;
    check("rst2_state", dut.route_q, 0);
    rx_in.tvalid = 1'b1;
    set_ch(1, 1, 1, 1, 1, 32'h0000_00F1);
    step();
    clear_beat();
    check("rst2_mmio_vld", mmio_out.tvalid, 1);
    check("rst2_mmio_ch1", mmio_out.tdata[1].hdr, 32'h0000_00F1);
    check("rst2_dma_vld", dma_out.tvalid, 0);
    check("rst2_err", err_cnt, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
